if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the PC register, the next-PC select, the request/ready handshake to instruction memory, and the IF/ID pipeline register. It consumes the stall/flush/redirect controls from the hazard controller and feeds the ID stage. It supports a single outstanding fetch with variable memory latency. Stalled responses are parked in a one-entry hold buffer. Responses that become stale after a redirect are discarded.

---
 rtl/if_stage_if.sv | 22 ++
 rtl/if_stage.sv | 151 +++++++++++++++
 tb/tb_if_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage and imem.
// One outstanding request; im_ready qualifies im_rdata in-cycle.
interface if_stage_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic [31:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ready,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ready,
        output im_rdata
    );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC, next-PC select, imem
// handshake, one-entry hold buffer and the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        IFID_RegWrite,
    input  logic        InstrFlush,
    input  logic [1:0]  BranchCtrl,
    input  logic [31:0] pc_imm,
    input  logic [31:0] pc_jalr,
    if_stage_if.master  im,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_instr,
    output logic        ID_valid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic [31:0] hold_instr_q;
    logic [31:0] hold_pc_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_instr_q;
    logic        id_valid_q;

    logic        redirect_d;
    logic        stall_d;
    logic [31:0] target_d;
    logic [31:0] pc_inc_d;
    logic [31:0] addr_sel_d;

    // Control decode and next-PC candidates.
    always_comb begin
        redirect_d = |BranchCtrl;
        stall_d    = !IFID_RegWrite || !PCWrite;
        target_d   = (BranchCtrl == 2'b01) ? pc_imm : pc_jalr;
        target_d   = target_d & 32'hFFFF_FFFC;
        pc_inc_d   = pc_q + 32'd4;
        addr_sel_d = (state_q == S_DROP) ? req_addr_q : pc_q;
    end

    // Fetch bus drive: DROP keeps the abandoned request alive
    // until memory answers so the handshake is never broken.
    assign im.im_req  = rst && (state_q != S_HOLD);
    assign im.im_addr = {addr_sel_d[31:2], 2'b00};

    assign ID_pc    = id_pc_q;
    assign ID_instr = id_instr_q;
    assign ID_valid = id_valid_q;

    // FSM, PC, hold buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            pc_q         <= {RESET_PC[31:2], 2'b00};
            req_addr_q   <= '0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= '0;
            id_pc_q      <= '0;
            id_instr_q   <= NOP_INSTR;
            id_valid_q   <= 1'b0;
        end else if (redirect_d) begin
            pc_q         <= target_d;
            id_pc_q      <= '0;
            id_instr_q   <= NOP_INSTR;
            id_valid_q   <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= '0;
            unique case (state_q)
                S_FETCH: begin
                    if (!im.im_ready) begin
                        state_q    <= S_DROP;
                        req_addr_q <= pc_q;
                    end
                end
                S_HOLD: state_q <= S_FETCH;
                S_DROP: begin
                    if (im.im_ready) begin
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end else if (stall_d) begin
            unique case (state_q)
                S_FETCH: begin
                    if (im.im_ready) begin
                        state_q      <= S_HOLD;
                        hold_instr_q <= im.im_rdata;
                        hold_pc_q    <= pc_q;
                    end
                end
                S_HOLD: state_q <= S_HOLD;
                S_DROP: begin
                    if (im.im_ready) begin
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (im.im_ready && !InstrFlush) begin
                        id_pc_q    <= pc_q;
                        id_instr_q <= im.im_rdata;
                        id_valid_q <= 1'b1;
                        pc_q       <= pc_inc_d;
                    end else begin
                        id_pc_q    <= '0;
                        id_instr_q <= NOP_INSTR;
                        id_valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    state_q <= S_FETCH;
                    if (!InstrFlush) begin
                        id_pc_q    <= hold_pc_q;
                        id_instr_q <= hold_instr_q;
                        id_valid_q <= 1'b1;
                        pc_q       <= pc_inc_d;
                    end else begin
                        id_pc_q    <= '0;
                        id_instr_q <= NOP_INSTR;
                        id_valid_q <= 1'b0;
                    end
                end
                S_DROP: begin
                    id_pc_q    <= '0;
                    id_instr_q <= NOP_INSTR;
                    id_valid_q <= 1'b0;
                    if (im.im_ready) begin
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stimulus pushes expected IF/ID
// contents, a monitor pops them as the ID stage consumes them.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite;
    logic        IFID_RegWrite;
    logic        InstrFlush;
    logic [1:0]  BranchCtrl;
    logic [31:0] pc_imm;
    logic [31:0] pc_jalr;
    logic        ready_r;
    logic [31:0] ID_pc;
    logic [31:0] ID_instr;
    logic        ID_valid;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    if_stage_if im_bus ();

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hC0DE_0033;
    endfunction

    assign im_bus.im_ready = ready_r;
    assign im_bus.im_rdata = f(im_bus.im_addr);

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PCWrite      (PCWrite),
        .IFID_RegWrite(IFID_RegWrite),
        .InstrFlush   (InstrFlush),
        .BranchCtrl   (BranchCtrl),
        .pc_imm       (pc_imm),
        .pc_jalr      (pc_jalr),
        .im           (im_bus.master),
        .ID_pc        (ID_pc),
        .ID_instr     (ID_instr),
        .ID_valid     (ID_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of controls just after the falling edge.
    task automatic cyc(input logic rs, input logic rdy,
                       input logic [1:0] bc, input logic [31:0] tgt,
                       input logic st, input logic fl);
        @(negedge clk);
        rst           = rs;
        ready_r       = rdy;
        BranchCtrl    = bc;
        pc_imm        = (bc == 2'b01) ? tgt : 32'h0000_2EB4;
        pc_jalr       = bc[1] ? tgt : 32'h0000_0777;
        PCWrite       = !st;
        IFID_RegWrite = !st;
        InstrFlush    = fl;
        #1;
    endtask

    // ID-side monitor: an instruction is consumed when it is valid
    // and IF/ID is allowed to advance at the coming edge.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b1 && IFID_RegWrite && ID_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_id got pc %h want none",
                             ID_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("ID_pc", ID_pc, e);
                    chk("ID_instr", ID_instr, f(e));
                end
            end else if (ID_valid === 1'b0) begin
                chk("bubble_instr", ID_instr, 32'h0000_0013);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        ready_r = 1'b1;
        PCWrite = 1'b1;
        IFID_RegWrite = 1'b1;
        InstrFlush = 1'b0;
        BranchCtrl = 2'b00;
        pc_imm = '0;
        pc_jalr = '0;

        // Reset state.
        repeat (3) cyc(0, 1, 2'b00, 0, 0, 0);
        chk("rst_req", {31'd0, im_bus.im_req}, 0);
        chk("rst_valid", {31'd0, ID_valid}, 0);
        chk("rst_instr", ID_instr, 32'h13);
        chk("rst_pc", ID_pc, 0);

        // Zero-wait streaming.
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("req0", {31'd0, im_bus.im_req}, 1);
        chk("addr0", im_bus.im_addr, 32'h0);
        exp_q.push_back(32'h0);
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("addr4", im_bus.im_addr, 32'h4);
        chk("valid_c2", {31'd0, ID_valid}, 1);
        exp_q.push_back(32'h4);

        // Three wait cycles at 0x8.
        cyc(1, 0, 2'b00, 0, 0, 0);
        chk("addr8_w0", im_bus.im_addr, 32'h8);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 2'b00, 0, 0, 0);
            chk("req_wait", {31'd0, im_bus.im_req}, 1);
            chk("addr8_wait", im_bus.im_addr, 32'h8);
            chk("valid_wait", {31'd0, ID_valid}, 0);
        end
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("addr8_rdy", im_bus.im_addr, 32'h8);
        chk("valid_w3", {31'd0, ID_valid}, 0);
        exp_q.push_back(32'h8);
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("addrC", im_bus.im_addr, 32'hC);
        chk("idpc8", ID_pc, 32'h8);
        exp_q.push_back(32'hC);

        // Load-use stall parks 0x10 in the hold buffer.
        cyc(1, 1, 2'b00, 0, 1, 0);
        chk("addr10", im_bus.im_addr, 32'h10);
        chk("req_stall", {31'd0, im_bus.im_req}, 1);
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("req_hold", {31'd0, im_bus.im_req}, 0);
        exp_q.push_back(32'h10);
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("addr14", im_bus.im_addr, 32'h14);
        chk("idpc10", ID_pc, 32'h10);
        exp_q.push_back(32'h14);
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("addr18", im_bus.im_addr, 32'h18);
        exp_q.push_back(32'h18);
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("addr1C", im_bus.im_addr, 32'h1C);
        exp_q.push_back(32'h1C);

        // Branch while 0x20 is outstanding.
        cyc(1, 0, 2'b00, 0, 0, 0);
        chk("addr20", im_bus.im_addr, 32'h20);
        cyc(1, 0, 2'b01, 32'h100, 0, 1);
        chk("addr20_br", im_bus.im_addr, 32'h20);
        cyc(1, 0, 2'b00, 0, 0, 0);
        chk("req_drop", {31'd0, im_bus.im_req}, 1);
        chk("addr_drop", im_bus.im_addr, 32'h20);
        chk("valid_drop", {31'd0, ID_valid}, 0);
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("addr_drop_rdy", im_bus.im_addr, 32'h20);
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("addr100", im_bus.im_addr, 32'h100);
        chk("valid_gap", {31'd0, ID_valid}, 0);
        exp_q.push_back(32'h100);

        // jalr redirect while in HOLD.
        cyc(1, 1, 2'b00, 0, 1, 0);
        chk("addr104", im_bus.im_addr, 32'h104);
        cyc(1, 1, 2'b10, 32'h203, 0, 1);
        chk("req_hold2", {31'd0, im_bus.im_req}, 0);
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("addr200", im_bus.im_addr, 32'h200);
        chk("valid_jalr", {31'd0, ID_valid}, 0);
        exp_q.push_back(32'h200);

        // Redirect with ready discards 0x204; then wrap at top.
        cyc(1, 1, 2'b01, 32'hFFFF_FFFC, 0, 1);
        chk("addr204", im_bus.im_addr, 32'h204);
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("addr_top", im_bus.im_addr, 32'hFFFF_FFFC);
        chk("valid_br2", {31'd0, ID_valid}, 0);
        exp_q.push_back(32'hFFFF_FFFC);
        cyc(1, 0, 2'b00, 0, 0, 0);
        chk("addr_wrap", im_bus.im_addr, 32'h0);
        chk("idpc_top", ID_pc, 32'hFFFF_FFFC);

        // Reset in the middle of DROP.
        cyc(1, 0, 2'b01, 32'h40, 0, 1);
        chk("addr_pre_drop", im_bus.im_addr, 32'h0);
        cyc(1, 0, 2'b00, 0, 0, 0);
        chk("req_drop2", {31'd0, im_bus.im_req}, 1);
        chk("addr_drop2", im_bus.im_addr, 32'h0);
        cyc(0, 0, 2'b00, 0, 0, 0);
        chk("req_in_rst", {31'd0, im_bus.im_req}, 0);
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("req_post_rst", {31'd0, im_bus.im_req}, 1);
        chk("addr_post_rst", im_bus.im_addr, 32'h0);
        chk("valid_post_rst", {31'd0, ID_valid}, 0);
        exp_q.push_back(32'h0);
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("addr4_b", im_bus.im_addr, 32'h4);
        chk("idpc0_b", ID_pc, 32'h0);
        exp_q.push_back(32'h4);

        // Flush without redirect: bubble, PC does not advance.
        cyc(1, 1, 2'b00, 0, 0, 1);
        chk("addr8_fl", im_bus.im_addr, 32'h8);
        cyc(1, 1, 2'b00, 0, 0, 0);
        chk("addr8_refetch", im_bus.im_addr, 32'h8);
        chk("valid_fl", {31'd0, ID_valid}, 0);
        exp_q.push_back(32'h8);
        cyc(1, 0, 2'b00, 0, 0, 0);
        chk("addrC_b", im_bus.im_addr, 32'hC);
        cyc(1, 0, 2'b00, 0, 0, 0);
        chk("valid_end", {31'd0, ID_valid}, 0);
        #2;
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
